// File: rtl/mem_access_ctrl.sv
// Data-RAM access controller: formats loads, issues direct or read-modify-write stores,
// and flags misaligned or illegal accesses with a one-cycle error response.
module mem_access_ctrl #(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [AWIDTH+1:0]   req_addr,
    input  logic [DWIDTH-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic                rsp_err,
    output logic [DWIDTH-1:0]   rsp_rdata,
    output logic [AWIDTH-1:0]   ram_addr,
    output logic [DWIDTH-1:0]   ram_qin,
    output logic [2:0]          ram_we,
    input  logic [DWIDTH-1:0]   ram_qout
);

    typedef enum logic [2:0] {
        IDLE,
        LD_ADDR,
        LD_DATA,
        RMW_RD,
        RMW_MRG,
        WR,
        RSP,
        ERR
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [1:0]        r_size;
    logic [1:0]        r_off;
    logic              r_unsigned;
    logic [15:0]       r_wdata;

    logic [AWIDTH-1:0] r_ram_addr;
    logic [DWIDTH-1:0] r_ram_qin;
    logic [2:0]        r_ram_we;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [DWIDTH-1:0] r_rsp_rdata;

    logic              w_accept;
    logic              w_misalign;
    logic              w_direct;
    logic [7:0]        w_ld_byte;
    logic [15:0]       w_ld_half;
    logic [DWIDTH-1:0] w_ld_fmt;
    logic [DWIDTH-1:0] w_merged;

    logic [2:0]        w_we_nxt;
    logic [DWIDTH-1:0] w_qin_nxt;
    logic              w_rsp_valid_nxt;
    logic              w_rsp_err_nxt;
    logic [DWIDTH-1:0] w_rdata_nxt;

    assign req_ready = (r_state == IDLE);
    assign w_accept  = req_valid & req_ready;
    assign w_direct  = (req_addr[1:0] == 2'b00);

    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
    assign ram_addr  = r_ram_addr;
    assign ram_qin   = r_ram_qin;
    assign ram_we    = r_ram_we;

    always_comb begin
        case (req_size)
            2'b00:   w_misalign = 1'b0;
            2'b01:   w_misalign = req_addr[0];
            2'b10:   w_misalign = |req_addr[1:0];
            default: w_misalign = 1'b1;
        endcase
    end

    always_comb begin
        w_ld_byte = ram_qout[{r_off, 3'b000} +: 8];
        w_ld_half = r_off[1] ? ram_qout[31:16] : ram_qout[15:0];
        case (r_size)
            2'b00:   w_ld_fmt = {{(DWIDTH-8){w_ld_byte[7] & ~r_unsigned}}, w_ld_byte};
            2'b01:   w_ld_fmt = {{(DWIDTH-16){w_ld_half[15] & ~r_unsigned}}, w_ld_half};
            default: w_ld_fmt = ram_qout;
        endcase
    end

    // Only byte stores at 01/10/11 and halfword stores at 10 reach the merge.
    always_comb begin
        w_merged = ram_qout;
        if (r_size == 2'b00) begin
            w_merged[{r_off, 3'b000} +: 8] = r_wdata[7:0];
        end else begin
            w_merged[31:16] = r_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output values are computed for the state being entered, so the registered
    // outputs line up with WR, RSP and ERR without any combinational path.
    always_comb begin
        w_state_nxt     = r_state;
        w_we_nxt        = 3'b000;
        w_qin_nxt       = r_ram_qin;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_err_nxt   = 1'b0;
        w_rdata_nxt     = '0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_misalign) begin
                        w_state_nxt     = ERR;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                    end else if (!req_write) begin
                        w_state_nxt = LD_ADDR;
                    end else if (w_direct) begin
                        w_state_nxt = WR;
                        w_we_nxt    = {1'b1, req_size};
                        w_qin_nxt   = req_wdata;
                    end else begin
                        w_state_nxt = RMW_RD;
                    end
                end
            end
            LD_ADDR: begin
                w_state_nxt = LD_DATA;
            end
            LD_DATA: begin
                w_state_nxt     = RSP;
                w_rsp_valid_nxt = 1'b1;
                w_rdata_nxt     = w_ld_fmt;
            end
            RMW_RD: begin
                w_state_nxt = RMW_MRG;
            end
            RMW_MRG: begin
                w_state_nxt = WR;
                w_we_nxt    = 3'b110;
                w_qin_nxt   = w_merged;
            end
            WR: begin
                w_state_nxt     = RSP;
                w_rsp_valid_nxt = 1'b1;
            end
            RSP: begin
                w_state_nxt = IDLE;
            end
            ERR: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_size     <= '0;
            r_off      <= '0;
            r_unsigned <= 1'b0;
            r_wdata    <= '0;
        end else if (w_accept) begin
            r_size     <= req_size;
            r_off      <= req_addr[1:0];
            r_unsigned <= req_unsigned;
            r_wdata    <= req_wdata[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_addr  <= '0;
            r_ram_qin   <= '0;
            r_ram_we    <= 3'b000;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_ram_qin   <= w_qin_nxt;
            r_ram_we    <= w_we_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_rdata <= w_rdata_nxt;
            if (w_accept && !w_misalign) begin
                r_ram_addr <= req_addr[AWIDTH+1:2];
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: synchronous read-first RAM model, per-transaction
// latency/response/write checks and RAM content checks against hand-computed values.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [13:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [11:0] ram_addr;
    logic [31:0] ram_qin;
    logic [2:0]  ram_we;
    logic [31:0] ram_qout;

    logic        do_init;
    logic [31:0] mem [0:4095];

    int total;
    int bad;

    mem_access_ctrl #(
        .AWIDTH(12),
        .DWIDTH(32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_err     (rsp_err),
        .rsp_rdata   (rsp_rdata),
        .ram_addr    (ram_addr),
        .ram_qin     (ram_qin),
        .ram_we      (ram_we),
        .ram_qout    (ram_qout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (do_init) begin
            mem[3]    <= 32'h11223344;
            mem[5]    <= 32'h80FF7F01;
            mem[8]    <= 32'h01234567;
            mem[4095] <= 32'hA5A55A5A;
        end else if (ram_we[2]) begin
            case (ram_we[1:0])
                2'b00:   mem[ram_addr][7:0]  <= ram_qin[7:0];
                2'b01:   mem[ram_addr][15:0] <= ram_qin[15:0];
                2'b10:   mem[ram_addr]       <= ram_qin;
                default: ;
            endcase
        end
        ram_qout <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge in IDLE and ends at a negedge back in IDLE.
    task automatic txn(input string tag, input logic w, input logic [1:0] sz, input logic uns,
                       input logic [13:0] a, input logic [31:0] wd, input int lat,
                       input logic xerr, input logic [31:0] xrd, input logic [2:0] xwe);
        int          rsp_k;
        int          rsp_n;
        int          wr_n;
        logic [2:0]  we_obs;
        logic        err_obs;
        logic [31:0] rd_obs;
        logic [11:0] ra_obs;
        rsp_k = 0; rsp_n = 0; wr_n = 0;
        we_obs = 3'b000; err_obs = 1'b0; rd_obs = '0; ra_obs = '0;
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        check({tag, ":ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_write = ~w; req_size = ~sz; req_unsigned = ~uns;
        req_addr = ~a; req_wdata = ~wd;
        for (int k = 1; k <= lat + 1; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 1) ra_obs = ram_addr;
            if (ram_we != 3'b000) begin
                we_obs = ram_we;
                if (ram_we[2]) wr_n++;
            end
            if (rsp_valid) begin
                rsp_n++;
                rsp_k   = k;
                err_obs = rsp_err;
                rd_obs  = rsp_rdata;
            end
        end
        check({tag, ":rsp_cycle"}, 32'(rsp_k), 32'(lat));
        check({tag, ":rsp_count"}, 32'(rsp_n), 32'd1);
        check({tag, ":rsp_err"}, 32'(err_obs), 32'(xerr));
        check({tag, ":rsp_rdata"}, rd_obs, xrd);
        check({tag, ":write_count"}, 32'(wr_n), 32'(xwe[2]));
        check({tag, ":ram_we"}, 32'(we_obs), 32'(xwe));
        if (!xerr) check({tag, ":ram_addr"}, 32'(ra_obs), 32'(a[13:2]));
        check({tag, ":ready_after"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int          viol;
        logic [11:0] rdy_bits;
        logic [11:0] rsp_bits;
        int          b2b_bad;

        total = 0; bad = 0;
        clk = 1'b0; rst_n = 1'b1; do_init = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;

        #2 rst_n = 1'b0;
        #1;
        check("reset:req_ready", 32'(req_ready), 32'd1);
        check("reset:rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset:rsp_err", 32'(rsp_err), 32'd0);
        check("reset:rsp_rdata", rsp_rdata, 32'd0);
        check("reset:ram_addr", 32'(ram_addr), 32'd0);
        check("reset:ram_qin", ram_qin, 32'd0);
        check("reset:ram_we", 32'(ram_we), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; do_init = 1'b0;

        // loads from word 5 = 0x80FF7F01 and word 4095
        txn("ld_b_s_16",  1'b0, 2'b00, 1'b0, 14'h0016, 32'h0, 3, 1'b0, 32'hFFFFFFFF, 3'b000);
        txn("ld_b_u_16",  1'b0, 2'b00, 1'b1, 14'h0016, 32'h0, 3, 1'b0, 32'h000000FF, 3'b000);
        txn("ld_h_s_16",  1'b0, 2'b01, 1'b0, 14'h0016, 32'h0, 3, 1'b0, 32'hFFFF80FF, 3'b000);
        txn("ld_h_u_14",  1'b0, 2'b01, 1'b1, 14'h0014, 32'h0, 3, 1'b0, 32'h00007F01, 3'b000);
        txn("ld_b_s_15",  1'b0, 2'b00, 1'b0, 14'h0015, 32'h0, 3, 1'b0, 32'h0000007F, 3'b000);
        txn("ld_b_s_14",  1'b0, 2'b00, 1'b0, 14'h0014, 32'h0, 3, 1'b0, 32'h00000001, 3'b000);
        txn("ld_w_3ffc",  1'b0, 2'b10, 1'b0, 14'h3FFC, 32'h0, 3, 1'b0, 32'hA5A55A5A, 3'b000);

        // stores
        txn("st_b_rmw_0d", 1'b1, 2'b00, 1'b0, 14'h000D, 32'h000000AB, 4, 1'b0, 32'h0, 3'b110);
        check("mem3_after_rmw", mem[3], 32'h1122AB44);
        txn("st_h_dir_20", 1'b1, 2'b01, 1'b0, 14'h0020, 32'hDEADBEEF, 2, 1'b0, 32'h0, 3'b101);
        check("mem8_after_dir_h", mem[8], 32'h0123BEEF);
        txn("st_h_rmw_22", 1'b1, 2'b01, 1'b0, 14'h0022, 32'h1234CAFE, 4, 1'b0, 32'h0, 3'b110);
        check("mem8_after_rmw_h", mem[8], 32'hCAFEBEEF);
        txn("st_w_dir_30", 1'b1, 2'b10, 1'b0, 14'h0030, 32'h12345678, 2, 1'b0, 32'h0, 3'b110);
        txn("st_b_dir_30", 1'b1, 2'b00, 1'b0, 14'h0030, 32'hFFFFFF9A, 2, 1'b0, 32'h0, 3'b100);
        check("mem12_after_dir_b", mem[12], 32'h1234569A);
        txn("st_b_rmw_33", 1'b1, 2'b00, 1'b0, 14'h0033, 32'h00000077, 4, 1'b0, 32'h0, 3'b110);
        txn("ld_w_30",     1'b0, 2'b10, 1'b0, 14'h0030, 32'h0, 3, 1'b0, 32'h7734569A, 3'b000);

        // misaligned and illegal
        txn("err_ld_w_02", 1'b0, 2'b10, 1'b0, 14'h0002, 32'h0, 1, 1'b1, 32'h0, 3'b000);
        txn("err_st_h_21", 1'b1, 2'b01, 1'b0, 14'h0021, 32'h5555AAAA, 1, 1'b1, 32'h0, 3'b000);
        check("mem8_after_err", mem[8], 32'hCAFEBEEF);
        txn("err_size11",  1'b0, 2'b11, 1'b0, 14'h0000, 32'h0, 1, 1'b1, 32'h0, 3'b000);

        // reset in RMW_MRG
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 14'h000D; req_wdata = 32'h00000055;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mrg:ram_we", 32'(ram_we), 32'd0);
        check("rst_mrg:rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mrg:ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        viol = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid || ram_we != 3'b000) viol++;
            @(negedge clk);
        end
        check("rst_mrg:quiet_cycles", 32'(viol), 32'd0);
        check("rst_mrg:mem3", mem[3], 32'h1122AB44);
        txn("after_rst_ld_b", 1'b0, 2'b00, 1'b1, 14'h000D, 32'h0, 3, 1'b0, 32'h000000AB, 3'b000);

        // back-to-back loads with req_valid held
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 14'h0014; req_wdata = '0;
        rdy_bits = '0; rsp_bits = '0; b2b_bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            rdy_bits[i] = req_ready;
            rsp_bits[i] = rsp_valid;
            if (rsp_valid && rsp_rdata !== 32'h80FF7F01) b2b_bad++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b:ready_pattern", 32'(rdy_bits), 32'h111);
        check("b2b:rsp_pattern", 32'(rsp_bits), 32'h888);
        check("b2b:rdata_errors", 32'(b2b_bad), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have parameter AWIDTH, default 12, meaning the data RAM word-address width.
REQ-002 The block SHALL have parameter DWIDTH, default 32, meaning the data word width; only 32 is supported.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: access request from the pipeline.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the request is accepted on a clock edge where req_valid and req_ready are both 1.
REQ-007 The block SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-008 The block SHALL have port req_size, input, 2 bits: 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
REQ-009 The block SHALL have port req_unsigned, input, 1 bit: load zero-extend when 1, sign-extend when 0.
REQ-010 The block SHALL have port req_addr, input, AWIDTH+2 bits: byte address.
REQ-011 The block SHALL have port req_wdata, input, DWIDTH bits: store data, right-justified.
REQ-012 The block SHALL have port rsp_valid, output, 1 bit: a one-cycle completion pulse with no back-pressure.
REQ-013 The block SHALL have port rsp_err, output, 1 bit: qualified by rsp_valid; 1 = misaligned or illegal access.
REQ-014 The block SHALL have port rsp_rdata, output, DWIDTH bits: formatted load data, qualified by rsp_valid on loads.
REQ-015 The block SHALL have port ram_addr, output, AWIDTH bits: data RAM word address, equal to req_addr[AWIDTH+1:2].
REQ-016 The block SHALL have port ram_qin, output, DWIDTH bits: data RAM write data.
REQ-017 The block SHALL have port ram_we, output, 3 bits: RAM write enable; bit2 = write, bits[1:0] = size; lanes written from byte 0 only (100 = lane0, 101 = lanes0-1, 110 = all lanes, 0xx = no write).
REQ-018 The block SHALL have port ram_qout, input, DWIDTH bits: RAM read data, valid one cycle after the address is presented (read-first).

Function
REQ-019 The block SHALL register all RAM-side outputs and rsp_* outputs; there are no combinational paths from req_* to outputs other than req_ready.
REQ-020 The block SHALL implement FSM states IDLE, LD_ADDR, LD_DATA, RMW_RD, RMW_MRG, WR, RSP and ERR; req_ready SHALL be 1 only in IDLE.
REQ-021 On acceptance, misalignment SHALL be detected and cause IDLE->ERR with no RAM access (ram_we stays 0xx): size 11, halfword with addr[0]=1, or word with addr[1:0]!=00.
REQ-022 In ERR (one cycle), the block SHALL output rsp_valid=1, rsp_err=1 and rsp_rdata=0, then return to IDLE.
REQ-023 For an accepted load, the block SHALL follow IDLE->LD_ADDR->LD_DATA->RSP->IDLE; it captures ram_qout in LD_DATA and pulses rsp_valid in RSP, i.e. three cycles after the acceptance edge.
REQ-024 Load format SHALL be: byte = qout[8*o+7:8*o] with o=addr[1:0]; halfword = qout[16*addr[1]+15:16*addr[1]]; word = qout; extended to 32 bits per req_unsigned.
REQ-025 Direct stores SHALL follow IDLE->WR->RSP: a byte store with addr[1:0]=00, a halfword store with addr[1:0]=00, or a word store; in WR, ram_we=1_ss (size code) and ram_qin=req_wdata.
REQ-026 Sub-word stores not at offset 0 (byte at 01/10/11, halfword at 10) SHALL use read-modify-write: IDLE->RMW_RD (ram_we=000)->RMW_MRG (merge target lanes of req_wdata into ram_qout, other lanes preserved)->WR (ram_we=110, merged word)->RSP.
REQ-027 A store response SHALL have rsp_valid=1, rsp_err=0 and rsp_rdata=0; direct store rsp occurs at acceptance+2 cycles, RMW store rsp at acceptance+4 cycles.
REQ-028 ram_we SHALL be 0xx in every state except WR, and exactly one write cycle SHALL occur per store.
REQ-029 req_* inputs SHALL be captured at acceptance; changes to them during a transaction SHALL have no effect.
REQ-030 A new request SHALL be accepted no earlier than the cycle after RSP or ERR, i.e. the first IDLE cycle.
REQ-031 Address wrap SHALL NOT occur; ram_addr is a pure truncation of the captured address.

Reset
REQ-032 When rst_n=0, asynchronously: state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, ram_addr=0, ram_qin=0, ram_we=000.
REQ-033 Reset asserted mid-transaction SHALL abort it with no response and force ram_we to 000 immediately, including during WR.

Verification
REQ-034 Load byte signed: RAM[5]=0x80FF7F01, req addr=0x16, size=00 -> rsp at accept+3, rdata=0xFFFFFFFF; with unsigned=1, rdata=0x000000FF.
REQ-035 RMW byte store: RAM[3]=0x11223344, store byte 0xAB to addr 0x0D -> single write with ram_we=110, RAM[3]=0x1122AB44, rsp at accept+4.
REQ-036 Direct halfword store: addr 0x20, wdata=0xDEADBEEF, size=01 -> ram_we=101 for one cycle, RAM[8] low half=0xBEEF, rsp at accept+2.
REQ-037 Misaligned word load at addr 0x02 -> rsp_valid and rsp_err=1 at accept+1, no RAM access, rdata=0.
REQ-038 Reset pulse during RMW_MRG -> ram_we=000, no write to RAM, no rsp; next request is accepted normally.
REQ-039 Back-to-back loads with req_valid held high -> accepts spaced 4 cycles apart, req_ready=0 between them.
